// File: rtl/viterbi_datapath.sv
// Datapath of a 16-word, 11-tag Viterbi POS tagger: ROMs, counters, probability columns,
// max/argmax unit and backtrack stack, sequenced entirely by an external controller.
module viterbi_datapath #(
  parameter int word_num     = 16,
  parameter int word_num_bit = 4,
  parameter int p_size       = 32,
  parameter int POS_num      = 11,
  parameter int POS_num_bit  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    increment_enable_Words_control,
  input  logic                    increment_enable_Emiss_control,
  input  logic                    increment_enable_Transition_control,
  input  logic                    RW_Key_reg,
  input  logic                    decrement_enable,
  input  logic                    RW_Stack_POS,
  input  logic                    RW_Pre_addr_encode,
  input  logic                    RW_Pre_Posibility,
  input  logic                    S_key_0,
  input  logic                    S_key_1,
  input  logic                    S_POS_HMM_0,
  input  logic                    S_POS_HMM_1,
  input  logic                    S_POS_HMM_2,
  input  logic                    S_posibility_0,
  input  logic                    S_posibility_1,
  input  logic                    RW_HMM_matrix,
  input  logic                    change_enable,
  input  logic                    choose_output,
  input  logic                    RW_Max_posibility,
  output logic [word_num_bit-1:0] i,
  output logic [POS_num_bit-1:0]  J,
  output logic [POS_num_bit-1:0]  trans_curr,
  output logic [word_num_bit-1:0] word_out,
  output logic [p_size-1:0]       emiss_out,
  output logic [p_size-1:0]       trans_out,
  output logic [p_size-1:0]       pre_pos_out,
  output logic [p_size-1:0]       hmm0,
  output logic [p_size-1:0]       hmm1,
  output logic [p_size-1:0]       hmm2,
  output logic [p_size-1:0]       hmm3,
  output logic [p_size-1:0]       hmm4,
  output logic [p_size-1:0]       hmm5,
  output logic [p_size-1:0]       hmm6,
  output logic [p_size-1:0]       hmm7,
  output logic [p_size-1:0]       hmm8,
  output logic [p_size-1:0]       hmm9,
  output logic [p_size-1:0]       hmm10,
  output logic [7:0]              key,
  output logic [POS_num_bit-1:0]  pre_encode_out,
  output logic [POS_num_bit-1:0]  hmm_pos,
  output logic [POS_num_bit-1:0]  max_pindex,
  output logic [POS_num_bit-1:0]  max_lastpos,
  output logic [POS_num_bit-1:0]  final_POS,
  output logic [POS_num-1:0]      hmm_preaddr,
  output logic [POS_num-1:0]      max_preaddr,
  output logic                    error,
  output logic                    endline,
  output logic                    multiple_source,
  output logic                    stack_empty
);

  localparam int LP_CW = $clog2(word_num + 1);
  localparam logic [word_num_bit-1:0] LP_W_ONE   = word_num_bit'(1);
  localparam logic [word_num_bit-1:0] LP_W_LAST  = word_num_bit'(word_num - 1);
  localparam logic [POS_num_bit-1:0]  LP_P_ONE   = POS_num_bit'(1);
  localparam logic [POS_num_bit-1:0]  LP_P_LAST  = POS_num_bit'(POS_num - 1);
  localparam logic [POS_num-1:0]      LP_OH_ONE  = POS_num'(1);
  localparam logic [LP_CW-1:0]        LP_C_ONE   = LP_CW'(1);
  localparam logic [LP_CW-1:0]        LP_C_DEPTH = LP_CW'(word_num);

  logic [word_num_bit-1:0] r_i;
  logic [POS_num_bit-1:0]  r_j, r_trans;
  logic [7:0]              r_key;
  logic [p_size-1:0]       r_hmm  [POS_num];
  logic [p_size-1:0]       r_prev [POS_num];
  logic [POS_num_bit-1:0]  r_hmmPos, r_maxLast, r_preEncode;
  logic [POS_num-1:0]      r_hmmPreaddr, r_maxPreaddr;
  logic [POS_num_bit-1:0]  r_stack [word_num];
  logic [LP_CW-1:0]        r_count;
  logic                    r_error;

  logic [5:0]              w_emSum, w_trSum;
  logic [2*p_size-1:0]     w_step1;
  logic [p_size-1:0]       w_chain, w_cand, w_hmmAtIdx, w_maxVal;
  logic [POS_num_bit-1:0]  w_idx, w_maxIdx, w_tieCnt, w_top;
  logic [word_num_bit-1:0] w_topAddr;
  logic                    w_accept, w_empty, w_full, w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_i     <= '0;
      r_j     <= '0;
      r_trans <= '0;
    end else begin
      if (increment_enable_Words_control)
        r_i <= (r_i == LP_W_LAST) ? '0 : r_i + LP_W_ONE;
      if (increment_enable_Emiss_control)
        r_j <= (r_j == LP_P_LAST) ? '0 : r_j + LP_P_ONE;
      if (increment_enable_Transition_control)
        r_trans <= (r_trans == LP_P_LAST) ? '0 : r_trans + LP_P_ONE;
    end
  end

  // ROMs are closed-form: word = 5i mod 16, E and T are small modular tables scaled to Q16.
  assign word_out  = r_i + {r_i[word_num_bit-3:0], 2'b00};
  assign w_emSum   = {2'b00, word_out} + {1'b0, word_out, 1'b0} + {2'b00, r_j};
  assign w_trSum   = {2'b00, r_trans} + {1'b0, r_j, 1'b0};
  assign emiss_out = p_size'({w_emSum % 6'd11 + 6'd1, 12'h000});
  assign trans_out = p_size'({w_trSum % 6'd11 + 6'd1, 12'h000});
  assign endline   = (r_i == LP_W_LAST);
  assign pre_pos_out = r_prev[r_trans];

  assign w_step1 = ((2*p_size)'(pre_pos_out) * (2*p_size)'(trans_out)) >> 16;
  assign w_chain = p_size'((w_step1 * (2*p_size)'(emiss_out)) >> 16);

  always_comb begin
    w_cand = '0;
    case ({S_posibility_1, S_posibility_0})
      2'b10:   w_cand = emiss_out;
      2'b01:   w_cand = w_chain;
      2'b11:   w_cand = pre_pos_out;
      default: w_cand = '0;
    endcase
  end

  always_comb begin
    w_idx = r_j;
    case ({S_POS_HMM_2, S_POS_HMM_1, S_POS_HMM_0})
      3'b010:  w_idx = r_trans;
      3'b100:  w_idx = w_maxIdx;
      default: w_idx = r_j;
    endcase
  end

  assign w_hmmAtIdx = r_hmm[w_idx];
  assign w_accept   = RW_HMM_matrix && !RW_Pre_Posibility && (w_idx <= LP_P_LAST) &&
                      (change_enable || (w_cand > w_hmmAtIdx));

  // Column shift wins over a write so a new time step always starts from an all-zero column.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < POS_num; k++) begin
        r_hmm[k]  <= '0;
        r_prev[k] <= '0;
      end
      r_hmmPos     <= '0;
      r_hmmPreaddr <= '0;
    end else if (RW_Pre_Posibility) begin
      for (int k = 0; k < POS_num; k++) begin
        r_prev[k] <= r_hmm[k];
        r_hmm[k]  <= '0;
      end
    end else if (w_accept) begin
      r_hmm[w_idx] <= w_cand;
      r_hmmPos     <= w_idx;
      r_hmmPreaddr <= LP_OH_ONE << r_trans;
    end
  end

  always_comb begin
    w_maxVal = '0;
    w_maxIdx = '0;
    w_tieCnt = '0;
    for (int k = 0; k < POS_num; k++) begin
      if (r_hmm[k] > w_maxVal) begin
        w_maxVal = r_hmm[k];
        w_maxIdx = POS_num_bit'(k);
      end
    end
    for (int k = 0; k < POS_num; k++) begin
      if (r_hmm[k] == w_maxVal) w_tieCnt = w_tieCnt + LP_P_ONE;
    end
  end

  assign multiple_source = (w_tieCnt > LP_P_ONE) && (w_maxVal != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key        <= '0;
      r_maxLast    <= '0;
      r_maxPreaddr <= '0;
      r_preEncode  <= '0;
    end else begin
      if (RW_Key_reg) begin
        case ({S_key_1, S_key_0})
          2'b00:   r_key <= {r_i, r_j};
          2'b01:   r_key <= {r_i, r_trans};
          2'b10:   r_key <= {word_out, r_j};
          default: r_key <= {word_out, r_trans};
        endcase
      end
      if (RW_Max_posibility) begin
        r_maxLast    <= w_maxIdx;
        r_maxPreaddr <= LP_OH_ONE << w_maxIdx;
      end
      if (RW_Pre_addr_encode) r_preEncode <= w_maxIdx;
    end
  end

  // A simultaneous push and pop behaves as a plain push.
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == LP_C_DEPTH);
  assign w_pop     = decrement_enable && !RW_Stack_POS;
  assign w_topAddr = word_num_bit'(r_count - LP_C_ONE);
  assign w_top     = w_empty ? '0 : r_stack[w_topAddr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < word_num; k++) r_stack[k] <= '0;
      r_count <= '0;
      r_error <= 1'b0;
    end else if (RW_Stack_POS) begin
      if (w_full) begin
        r_error <= 1'b1;
      end else begin
        r_stack[word_num_bit'(r_count)] <= w_maxIdx;
        r_count <= r_count + LP_C_ONE;
      end
    end else if (w_pop) begin
      if (w_empty) r_error <= 1'b1;
      else         r_count <= r_count - LP_C_ONE;
    end
  end

  assign i              = r_i;
  assign J              = r_j;
  assign trans_curr     = r_trans;
  assign key            = r_key;
  assign hmm_pos        = r_hmmPos;
  assign hmm_preaddr    = r_hmmPreaddr;
  assign max_pindex     = w_maxIdx;
  assign max_lastpos    = r_maxLast;
  assign max_preaddr    = r_maxPreaddr;
  assign pre_encode_out = r_preEncode;
  assign final_POS      = choose_output ? w_maxIdx : w_top;
  assign stack_empty    = w_empty;
  assign error          = r_error;
  assign hmm0  = r_hmm[0];
  assign hmm1  = r_hmm[1];
  assign hmm2  = r_hmm[2];
  assign hmm3  = r_hmm[3];
  assign hmm4  = r_hmm[4];
  assign hmm5  = r_hmm[5];
  assign hmm6  = r_hmm[6];
  assign hmm7  = r_hmm[7];
  assign hmm8  = r_hmm[8];
  assign hmm9  = r_hmm[9];
  assign hmm10 = r_hmm[10];

endmodule

// File: tb/tb_viterbi_datapath.sv
// Directed bench for viterbi_datapath: counters, ROMs, column update, max unit and stack,
// with expected values worked out by hand.
module tb_viterbi_datapath;

  logic clk, reset;
  logic incW, incE, incT, rwKey, decEn, rwStack, rwPreAddr, rwPrePos;
  logic sKey0, sKey1, sHmm0, sHmm1, sHmm2, sPos0, sPos1, rwHmm, changeEn, chooseOut, rwMax;
  logic [3:0]  i, J, transCurr, wordOut;
  logic [31:0] emissOut, transOut, prePosOut;
  logic [31:0] hmm [11];
  logic [7:0]  key;
  logic [3:0]  preEncodeOut, hmmPos, maxPindex, maxLastpos, finalPos;
  logic [10:0] hmmPreaddr, maxPreaddr;
  logic        error, endline, multipleSource, stackEmpty;

  int checkCount = 0;
  int errorCount = 0;

  viterbi_datapath dut (
    .clk(clk), .reset(reset),
    .increment_enable_Words_control(incW),
    .increment_enable_Emiss_control(incE),
    .increment_enable_Transition_control(incT),
    .RW_Key_reg(rwKey), .decrement_enable(decEn), .RW_Stack_POS(rwStack),
    .RW_Pre_addr_encode(rwPreAddr), .RW_Pre_Posibility(rwPrePos),
    .S_key_0(sKey0), .S_key_1(sKey1),
    .S_POS_HMM_0(sHmm0), .S_POS_HMM_1(sHmm1), .S_POS_HMM_2(sHmm2),
    .S_posibility_0(sPos0), .S_posibility_1(sPos1),
    .RW_HMM_matrix(rwHmm), .change_enable(changeEn), .choose_output(chooseOut),
    .RW_Max_posibility(rwMax),
    .i(i), .J(J), .trans_curr(transCurr), .word_out(wordOut),
    .emiss_out(emissOut), .trans_out(transOut), .pre_pos_out(prePosOut),
    .hmm0(hmm[0]), .hmm1(hmm[1]), .hmm2(hmm[2]), .hmm3(hmm[3]), .hmm4(hmm[4]),
    .hmm5(hmm[5]), .hmm6(hmm[6]), .hmm7(hmm[7]), .hmm8(hmm[8]), .hmm9(hmm[9]),
    .hmm10(hmm[10]),
    .key(key), .pre_encode_out(preEncodeOut), .hmm_pos(hmmPos),
    .max_pindex(maxPindex), .max_lastpos(maxLastpos), .final_POS(finalPos),
    .hmm_preaddr(hmmPreaddr), .max_preaddr(maxPreaddr),
    .error(error), .endline(endline), .multiple_source(multipleSource),
    .stack_empty(stackEmpty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearControls();
    incW = 0; incE = 0; incT = 0; rwKey = 0; decEn = 0; rwStack = 0; rwPreAddr = 0;
    rwPrePos = 0; sKey0 = 0; sKey1 = 0; sHmm0 = 0; sHmm1 = 0; sHmm2 = 0; sPos0 = 0;
    sPos1 = 0; rwHmm = 0; changeEn = 0; chooseOut = 0; rwMax = 0;
  endtask

  // Controls set by the caller are held for one rising edge, then dropped.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearControls();
  endtask

  initial begin
    clearControls();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checkOutput("rst_i", i, 0);
    checkOutput("rst_J", J, 0);
    checkOutput("rst_word", wordOut, 0);
    checkOutput("rst_emiss", emissOut, 32'h1000);
    checkOutput("rst_trans", transOut, 32'h1000);
    for (int k = 0; k < 11; k++) checkOutput($sformatf("rst_hmm%0d", k), hmm[k], 0);
    checkOutput("rst_empty", stackEmpty, 1);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_final", finalPos, 0);

    // Emission fill of the column at word 0
    for (int p = 0; p < 11; p++) begin
      incE = 1; sPos1 = 1; sHmm0 = 1; rwHmm = 1;
      applyStimulus();
    end
    for (int p = 0; p < 11; p++)
      checkOutput($sformatf("fill_hmm%0d", p), hmm[p], (p + 1) * 32'h1000);
    checkOutput("fill_max", maxPindex, 10);
    checkOutput("fill_multi", multipleSource, 0);
    checkOutput("fill_Jwrap", J, 0);
    checkOutput("fill_pos", hmmPos, 10);
    checkOutput("fill_preaddr", hmmPreaddr, 11'h001);

    rwPrePos = 1;
    applyStimulus();
    for (int k = 0; k < 11; k++) checkOutput($sformatf("shift_hmm%0d", k), hmm[k], 0);
    repeat (3) begin incT = 1; applyStimulus(); end
    checkOutput("trans3", transCurr, 3);
    checkOutput("prev3", prePosOut, 32'h4000);
    checkOutput("T30", transOut, 32'h4000);
    repeat (8) begin incT = 1; applyStimulus(); end
    checkOutput("trans_wrap", transCurr, 0);
    incW = 1;
    applyStimulus();
    checkOutput("i1", i, 1);
    checkOutput("word5", wordOut, 5);
    checkOutput("E50", emissOut, 32'h5000);

    // Candidate = prev*T*E over all previous tags, kept only when larger
    for (int a = 0; a < 11; a++) begin
      sPos0 = 1; rwHmm = 1; incT = 1;
      applyStimulus();
      if (a == 0) checkOutput("sweep_first", hmm[0], 80);
    end
    checkOutput("sweep_hmm0", hmm[0], 9680);
    checkOutput("sweep_preaddr", hmmPreaddr, 11'h400);
    checkOutput("sweep_pos", hmmPos, 0);
    rwKey = 1; sKey1 = 1;
    applyStimulus();
    checkOutput("key_wordJ", key, 8'h50);

    // Tie between hmm3 and hmm7
    rwPrePos = 1;
    applyStimulus();
    repeat (8) begin incE = 1; applyStimulus(); end
    checkOutput("E58", emissOut, 32'h2000);
    repeat (3) begin incT = 1; applyStimulus(); end
    rwKey = 1; sKey0 = 1;
    applyStimulus();
    checkOutput("key_iTrans", key, 8'h13);
    sHmm1 = 1; sPos1 = 1; rwHmm = 1; changeEn = 1;
    applyStimulus();
    checkOutput("w_hmm3", hmm[3], 32'h2000);
    checkOutput("single_multi", multipleSource, 0);
    repeat (4) begin incT = 1; applyStimulus(); end
    sHmm1 = 1; sPos1 = 1; rwHmm = 1; changeEn = 1;
    applyStimulus();
    checkOutput("w_hmm7", hmm[7], 32'h2000);
    checkOutput("tie_max", maxPindex, 3);
    checkOutput("tie_multi", multipleSource, 1);
    checkOutput("tie_pos", hmmPos, 7);
    checkOutput("tie_preaddr", hmmPreaddr, 11'h080);
    sHmm1 = 1; rwHmm = 1;
    applyStimulus();
    checkOutput("nochange_hmm7", hmm[7], 32'h2000);
    rwMax = 1; rwPreAddr = 1;
    applyStimulus();
    checkOutput("max_last", maxLastpos, 3);
    checkOutput("max_preaddr", maxPreaddr, 11'h008);
    checkOutput("pre_encode", preEncodeOut, 3);

    // Stack holds 3, 9, 10 from bottom to top
    rwStack = 1; applyStimulus();
    incE = 1; applyStimulus();
    checkOutput("E59", emissOut, 32'h3000);
    sPos1 = 1; rwHmm = 1; applyStimulus();
    checkOutput("max9", maxPindex, 9);
    rwStack = 1; applyStimulus();
    incE = 1; applyStimulus();
    sPos1 = 1; rwHmm = 1; applyStimulus();
    checkOutput("max10", maxPindex, 10);
    rwStack = 1; applyStimulus();
    checkOutput("top10", finalPos, 10);
    checkOutput("notempty", stackEmpty, 0);
    decEn = 1; applyStimulus();
    checkOutput("pop_top9", finalPos, 9);
    chooseOut = 1; #1;
    checkOutput("choose_max", finalPos, 10);
    chooseOut = 0;
    decEn = 1; applyStimulus();
    checkOutput("pop_top3", finalPos, 3);
    decEn = 1; applyStimulus();
    checkOutput("pop_empty", stackEmpty, 1);
    checkOutput("pop_emptytop", finalPos, 0);
    checkOutput("pop_noerr", error, 0);
    decEn = 1; applyStimulus();
    checkOutput("underflow_err", error, 1);
    checkOutput("underflow_empty", stackEmpty, 1);
    rwStack = 1; decEn = 1; applyStimulus();
    checkOutput("pushpop_empty", stackEmpty, 0);
    checkOutput("pushpop_top", finalPos, 10);

    rwPrePos = 1; sPos1 = 1; rwHmm = 1; changeEn = 1;
    applyStimulus();
    checkOutput("prio_hmm10", hmm[10], 0);

    // Asynchronous reset mid-cycle
    #3 reset = 1'b0;
    #1;
    checkOutput("areset_err", error, 0);
    checkOutput("areset_empty", stackEmpty, 1);
    checkOutput("areset_J", J, 0);
    checkOutput("areset_key", key, 0);
    #2 reset = 1'b1;

    repeat (15) begin incW = 1; applyStimulus(); end
    checkOutput("i15", i, 15);
    checkOutput("endline", endline, 1);
    checkOutput("word11", wordOut, 11);
    incW = 1; applyStimulus();
    checkOutput("i_wrap", i, 0);
    checkOutput("endline_off", endline, 0);

    repeat (16) begin rwStack = 1; applyStimulus(); end
    checkOutput("full_noerr", error, 0);
    rwStack = 1; applyStimulus();
    checkOutput("overflow_err", error, 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/viterbi_datapath.md
Name: viterbi_datapath

Overview:
- Datapath of a Viterbi POS tagger with 16 words and 11 POS tags. Probabilities are 32-bit unsigned Q16.
- Holds the word/emission/transition ROMs and their counters, the current and previous probability columns, max/argmax logic and the backtrack POS stack.
- All sequencing comes from an external controller through the enable and select inputs.

Parameters:
- word_num, 16, words per sentence.
- word_num_bit, 4, word index width.
- p_size, 32, probability width.
- POS_num, 11, number of POS tags.
- POS_num_bit, 4, POS index width.

Ports:
- clk in 1: rising-edge clock.
- reset in 1: asynchronous, active-low reset.
- increment_enable_Words_control, increment_enable_Emiss_control, increment_enable_Transition_control in 1 each: counter increments.
- RW_Key_reg in 1: key register load.
- decrement_enable in 1: stack pop.
- RW_Stack_POS in 1: stack push.
- RW_Pre_addr_encode in 1: backpointer latch.
- RW_Pre_Posibility in 1: copy current column to previous column.
- S_key_0, S_key_1 in 1: key source select.
- S_POS_HMM_0/1/2 in 1: HMM write index select.
- S_posibility_0/1 in 1: candidate select.
- RW_HMM_matrix in 1: HMM write.
- change_enable in 1: unconditional write.
- choose_output in 1: final_POS source.
- RW_Max_posibility in 1: max latch.
- i out 4: word counter.
- J out 4: emission/current-POS counter.
- trans_curr out 4: previous-POS counter.
- word_out out 4: word ROM data.
- emiss_out, trans_out, pre_pos_out out 32 each: probability values.
- hmm0..hmm10 out 32 each: current column.
- key out 8: key register.
- pre_encode_out, hmm_pos, max_pindex, max_lastpos, final_POS out 4 each: POS indices.
- hmm_preaddr, max_preaddr out 11 each: one-hot POS.
- error, endline, multiple_source, stack_empty out 1 each: status.

Behaviour:
- Reset (async, reset=0) clears every register, counter, HMM entry, previous-column entry, stack and error to 0. Afterwards stack_empty=1.
- All updates occur on the clk rising edge.
- i: +1 on Words increment, wraps 15->0.
- J: +1 on Emiss increment, wraps 10->0.
- trans_curr: +1 on Transition increment, wraps 10->0.
- Word ROM (combinational): word_out = (5*i) mod 16. endline = (i==15).
- Emission E(w,p) = (((3w+p) mod 11)+1)*4096. emiss_out = E(word_out, J).
- Transition T(a,b) = (((a+2b) mod 11)+1)*4096. trans_out = T(trans_curr, J).
- Key load when RW_Key_reg=1, source {S_key_1,S_key_0}:
  - 00: {i,J}
  - 01: {i,trans_curr}
  - 10: {word_out,J}
  - 11: {word_out,trans_curr}
- Candidate, selected by {S_posibility_1,S_posibility_0}:
  - 00: 0
  - 10: emiss_out
  - 01: (((pre_pos_out*trans_out)>>16)*emiss_out)>>16, 64-bit intermediates, truncated to 32 bits
  - 11: pre_pos_out
- Write index idx, selected by {S_POS_HMM_2,S_POS_HMM_1,S_POS_HMM_0}:
  - 010: trans_curr
  - 100: max_pindex
  - all other codes: J
- HMM write when RW_HMM_matrix=1: hmm[idx] <= candidate if change_enable=1 or candidate > hmm[idx]; otherwise no change.
- On every accepted write: hmm_pos <= idx and hmm_preaddr <= one-hot(trans_curr).
- RW_Pre_Posibility=1: prev[k] <= hmm[k] for all k and all hmm[k] <= 0 in the same cycle. This has priority over an HMM write in that cycle.
- pre_pos_out = prev[trans_curr].
- Max unit (combinational): max_pindex = argmax of hmm0..hmm10, lowest index on ties. multiple_source=1 when two or more entries equal the maximum and that maximum is nonzero.
- RW_Max_posibility=1: max_lastpos <= max_pindex, max_preaddr <= one-hot(max_pindex).
- RW_Pre_addr_encode=1: pre_encode_out <= max_pindex.
- Stack, 16-deep LIFO of 4-bit entries:
  - Push (RW_Stack_POS) stores max_pindex.
  - Pop (decrement_enable) removes the top.
  - Push and pop in the same cycle: pop is ignored.
  - Push when full or pop when empty: no change to the stack, and error is set sticky until reset.
  - stack_empty = (count==0). Top reads 0 when empty.
- final_POS = stack top when choose_output=0, max_pindex when choose_output=1.

Test Plan:
- Reset, then release -> i=0, J=0, word_out=0, emiss_out=0x1000, trans_out=0x1000, all hmm=0, stack_empty=1, error=0.
- Emission fill: Emiss increment with {S_pos}=10, HMM select 001, RW_HMM=1, change_enable=0 for 11 cycles -> hmm_p=(p+1)*0x1000, hmm10=0xB000, max_pindex=10, multiple_source=0, J wraps to 0.
- RW_Pre_Posibility one cycle -> all hmm=0. With trans_curr=3, pre_pos_out=0x4000.
- Words increment (i=1, word_out=5), J=0, {S_pos}=01, RW_HMM=1, trans_curr swept 0..10 -> hmm0=(a+1)^2*80 with a=10 winning, i.e. hmm0=9680, hmm_preaddr=11'h400, hmm_pos=0.
- Write hmm3 and hmm7 equal (change_enable=1, value 0x2000) with all others 0 -> max_pindex=3, multiple_source=1. RW_Max_posibility -> max_lastpos=3, max_preaddr=11'h008.
- Push max_pindex 3 times, then pop 4 times -> final_POS (choose_output=0) shows the top each pop, stack_empty=1 after the 3rd pop, error=1 after the 4th. Mid-sequence async reset -> error=0, stack_empty=1.
